cipher_round_ctrl: RTL and testbench
====================================

CIPHER_ROUND_CTRL -- requirements
Module: cipher_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, meaning number of cipher rounds (10/12/14 for AES-128/192/256).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_valid  in  1  requester offers a block to encrypt.
REQ-005 SHALL have port start_ready  out  1  controller accepts a block this cycle.
REQ-006 SHALL have port new_key  in  1  key for offered block differs from the stored schedule; sampled on acceptance.
REQ-007 SHALL have port ld_state  out  1  datapath loads plaintext and performs initial addRoundKey.
REQ-008 SHALL have port rnd_en  out  1  datapath performs one round (subBytes, shiftRows, mixColumns, addRoundKey).
REQ-009 SHALL have port mix_bypass  out  1  datapath skips mixColumns (final round).
REQ-010 SHALL have port key_we  out  1  key-expansion unit writes one round key.
REQ-011 SHALL have port key_addr  out  ceil(log2(NR+1))  round-key index for read (rounds) or write (expansion).
REQ-012 SHALL have port out_valid  out  1  ciphertext in datapath is complete.
REQ-013 SHALL have port out_ready  in  1  consumer takes the ciphertext.

Function
REQ-014 SHALL implement states IDLE, KEYEXP, INIT, ROUND, DONE in a registered FSM, with a round counter cnt of key_addr width.
REQ-015 SHALL drive start_ready=1 only in IDLE; acceptance = start_valid & start_ready.
REQ-016 On acceptance, SHALL go to KEYEXP with cnt=1 if new_key=1 or key_ok=0, else to INIT with cnt=0.
REQ-017 SHALL hold internal flag key_ok: cleared by reset, set on KEYEXP exit.
REQ-018 KEYEXP: key_we=1, key_addr=cnt, cnt increments each cycle; after the cycle with cnt=NR, SHALL go to INIT with cnt=0; duration exactly NR cycles.
REQ-019 INIT: ld_state=1, key_addr=0 for one cycle, then ROUND with cnt=1.
REQ-020 ROUND: rnd_en=1, key_addr=cnt, mix_bypass=1 only when cnt=NR; cnt increments; after cnt=NR SHALL go to DONE; duration exactly NR cycles.
REQ-021 DONE: out_valid=1 held stable until out_ready=1, then IDLE next cycle; no output other than out_valid asserted.
REQ-022 Latency: acceptance in cycle T -> out_valid first high in T+NR+2 without expansion, T+2*NR+2 with expansion.
REQ-023 In IDLE, KEYEXP, DONE SHALL hold ld_state=rnd_en=mix_bypass=0; key_we=0 in all states but KEYEXP; key_addr=0 in IDLE and DONE.
REQ-024 start_valid and new_key SHALL be ignored outside IDLE; out_ready ignored outside DONE.
REQ-025 out_ready=1 in DONE with start_valid=1 simultaneously: SHALL complete the handshake, then accept the new block only in the following IDLE cycle (no overlap).
REQ-026 cnt SHALL never exceed NR; no wrap-around path exists.

Reset
REQ-027 While rst=1 and at its release: state=IDLE, cnt=0, key_ok=0, start_ready=1, all other outputs 0.
REQ-028 rst asserted mid-KEYEXP or mid-ROUND SHALL abort immediately with no further key_we/rnd_en pulse; next block always re-expands the key.

Verification
REQ-029 First block after reset, new_key=0, NR=10 -> forced KEYEXP: key_we high 10 cycles, key_addr 1..10, then ld_state 1 cycle, rnd_en 10 cycles, out_valid at T+22.
REQ-030 Second block new_key=0 -> no key_we; ld_state at T+1, mix_bypass only at T+11 with key_addr=10, out_valid at T+12.
REQ-031 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1, start_ready stays 0, start_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-032 rst pulsed while cnt=4 in ROUND -> all outputs 0 asynchronously; next block with new_key=0 still runs KEYEXP.
REQ-033 NR=14 -> exactly 14 key_we and 14 rnd_en pulses, key_addr reaches 14, mix_bypass once.
REQ-034 Back-to-back blocks with start_valid constantly 1 and out_ready constantly 1 -> one IDLE cycle between DONE and next INIT/KEYEXP.

Source files
------------

// File: rtl/cipher_round_ctrl.sv
// Cipher round controller: sequences an optional key expansion, the initial
// state load and NR encryption rounds, then holds the result until taken.
module cipher_round_ctrl #(
    parameter int NR = 10,
    localparam int AW = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic          new_key,
    output logic          ld_state,
    output logic          rnd_en,
    output logic          mix_bypass,
    output logic          key_we,
    output logic [AW-1:0] key_addr,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEYEXP = 3'd1,
        INIT   = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(NR);
    localparam logic [AW-1:0] ONE  = AW'(1);
    localparam logic [AW-1:0] ZERO = '0;

    state_t        state, state_d;
    logic [AW-1:0] cnt, cnt_d;
    logic          key_ok, key_ok_d;

    // State, round counter and key-valid flag; reset forces a fresh key expansion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= ZERO;
            key_ok <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            key_ok <= key_ok_d;
        end
    end

    // Next-state logic and state-decoded datapath strobes
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        key_ok_d    = key_ok;
        start_ready = 1'b0;
        ld_state    = 1'b0;
        rnd_en      = 1'b0;
        mix_bypass  = 1'b0;
        key_we      = 1'b0;
        key_addr    = ZERO;
        out_valid   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    if (new_key || !key_ok) begin
                        state_d = KEYEXP;
                        cnt_d   = ONE;
                    end else begin
                        state_d = INIT;
                        cnt_d   = ZERO;
                    end
                end
            end
            KEYEXP: begin
                key_we   = 1'b1;
                key_addr = cnt;
                if (cnt == LAST) begin
                    state_d  = INIT;
                    cnt_d    = ZERO;
                    key_ok_d = 1'b1;
                end else begin
                    cnt_d = cnt + ONE;
                end
            end
            INIT: begin
                ld_state = 1'b1;
                key_addr = ZERO;
                state_d  = ROUND;
                cnt_d    = ONE;
            end
            ROUND: begin
                rnd_en     = 1'b1;
                key_addr   = cnt;
                mix_bypass = (cnt == LAST);
                if (cnt == LAST) begin
                    state_d = DONE;
                    cnt_d   = ZERO;
                end else begin
                    cnt_d = cnt + ONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = ZERO;
            end
        endcase
    end

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Testbench for cipher_round_ctrl: random handshakes checked cycle by cycle
// against a schedule model derived from the block latency rules.
module tb_cipher_round_ctrl;

    localparam int NR   = 10;
    localparam int AW   = $clog2(NR + 1);
    localparam int NR14 = 14;
    localparam int AW14 = $clog2(NR14 + 1);

    logic          clk;
    logic          rst;
    logic          start_valid;
    logic          new_key;
    logic          out_ready;
    logic          start_ready, ld_state, rnd_en, mix_bypass, key_we, out_valid;
    logic [AW-1:0] key_addr;
    logic            start_ready_14, ld_state_14, rnd_en_14, mix_bypass_14;
    logic            key_we_14, out_valid_14;
    logic [AW14-1:0] key_addr_14;

    logic [AW+5:0] obs;

    int checks = 0;
    int errors = 0;
    bit model_key_ok = 1'b0;

    cipher_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .new_key(new_key), .ld_state(ld_state), .rnd_en(rnd_en),
        .mix_bypass(mix_bypass), .key_we(key_we), .key_addr(key_addr),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    cipher_round_ctrl #(.NR(NR14)) dut14 (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready_14),
        .new_key(new_key), .ld_state(ld_state_14), .rnd_en(rnd_en_14),
        .mix_bypass(mix_bypass_14), .key_we(key_we_14), .key_addr(key_addr_14),
        .out_valid(out_valid_14), .out_ready(out_ready)
    );

    assign obs = {start_ready, ld_state, rnd_en, mix_bypass, key_we, key_addr, out_valid};

    // Free-running clock, rising edge active
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [AW+5:0] pack(input bit sr, input bit ld, input bit rn,
                                           input bit mb, input bit kw,
                                           input logic [AW-1:0] ka, input bit ov);
        return {sr, ld, rn, mb, kw, ka, ov};
    endfunction

    function automatic logic [AW+5:0] idle_vec();
        return pack(1, 0, 0, 0, 0, '0, 0);
    endfunction

    function automatic logic [AW+5:0] done_vec();
        return pack(0, 0, 0, 0, 0, '0, 1);
    endfunction

    // Expected outputs k cycles after acceptance (k >= 1), before DONE is reached:
    // optional NR key writes, one load, then NR rounds with the last one bypassing mix.
    function automatic logic [AW+5:0] model_out(input bit expand, input int k);
        int e;
        int r;
        e = expand ? NR : 0;
        if (k <= e) return pack(0, 0, 0, 0, 1, AW'(k), 0);
        if (k == e + 1) return pack(0, 1, 0, 0, 0, '0, 0);
        if (k <= e + 1 + NR) begin
            r = k - e - 1;
            return pack(0, 0, 1, (r == NR), 0, AW'(r), 0);
        end
        return done_vec();
    endfunction

    // Runs one block from an IDLE cycle to the IDLE cycle after the handshake.
    task automatic run_block(input bit nk, input int hold, input bit b2b,
                             output int n_kw, output int n_rnd, output int n_mix,
                             output int lat);
        bit expand;
        int total;
        int k;
        n_kw = 0; n_rnd = 0; n_mix = 0; lat = -1;
        checks++;
        if (obs !== idle_vec()) begin
            errors++;
            $display("[TB] FAIL idle_before_accept obs=%h exp=%h", obs, idle_vec());
        end
        start_valid = 1'b1;
        new_key     = nk;
        out_ready   = b2b ? 1'b1 : 1'($urandom);
        expand = nk || !model_key_ok;
        total  = (expand ? NR : 0) + NR + 1;
        for (k = 1; k <= total; k++) begin
            @(negedge clk);
            start_valid = b2b ? 1'b1 : 1'($urandom);
            new_key     = 1'($urandom);
            out_ready   = b2b ? 1'b1 : 1'($urandom);
            n_kw  += int'(key_we);
            n_rnd += int'(rnd_en);
            n_mix += int'(mix_bypass);
            if (out_valid && lat < 0) lat = k;
            checks++;
            if (obs !== model_out(expand, k)) begin
                errors++;
                $display("[TB] FAIL busy k=%0d expand=%0d obs=%h exp=%h",
                         k, expand, obs, model_out(expand, k));
            end
        end
        if (expand) model_key_ok = 1'b1;
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            if (out_valid && lat < 0) lat = total + 1 + h;
            checks++;
            if (obs !== done_vec()) begin
                errors++;
                $display("[TB] FAIL done_hold h=%0d obs=%h exp=%h", h, obs, done_vec());
            end
            start_valid = 1'b1;
            new_key     = 1'($urandom);
            out_ready   = (h == hold);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_valid = 1'b1;
        new_key = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (obs !== idle_vec()) begin
                errors++;
                $display("[TB] FAIL reset_hold obs=%h exp=%h", obs, idle_vec());
            end
        end
        rst = 1'b0;
        start_valid = 1'b0;
        model_key_ok = 1'b0;
        checks++;
        if (obs !== idle_vec()) begin
            errors++;
            $display("[TB] FAIL reset_release obs=%h exp=%h", obs, idle_vec());
        end
        @(negedge clk);
        checks++;
        if (obs !== idle_vec()) begin
            errors++;
            $display("[TB] FAIL idle_after_reset obs=%h exp=%h", obs, idle_vec());
        end
    endtask

    task automatic test_first_block();
        int n_kw, n_rnd, n_mix, lat;
        run_block(1'b0, 0, 1'b0, n_kw, n_rnd, n_mix, lat);
        checks++;
        if (n_kw !== NR || n_rnd !== NR || n_mix !== 1) begin
            errors++;
            $display("[TB] FAIL first_counts kw=%0d rnd=%0d mix=%0d exp=%0d/%0d/1",
                     n_kw, n_rnd, n_mix, NR, NR);
        end
        checks++;
        if (lat !== 2 * NR + 2) begin
            errors++;
            $display("[TB] FAIL first_latency got=%0d exp=%0d", lat, 2 * NR + 2);
        end
    endtask

    task automatic test_cached_key();
        int n_kw, n_rnd, n_mix, lat;
        start_valid = 1'b0;
        @(negedge clk);
        run_block(1'b0, 0, 1'b0, n_kw, n_rnd, n_mix, lat);
        checks++;
        if (n_kw !== 0 || n_rnd !== NR || n_mix !== 1) begin
            errors++;
            $display("[TB] FAIL cached_counts kw=%0d rnd=%0d mix=%0d exp=0/%0d/1",
                     n_kw, n_rnd, n_mix, NR);
        end
        checks++;
        if (lat !== NR + 2) begin
            errors++;
            $display("[TB] FAIL cached_latency got=%0d exp=%0d", lat, NR + 2);
        end
    endtask

    task automatic test_done_hold();
        int n_kw, n_rnd, n_mix, lat;
        run_block(1'b0, 5, 1'b0, n_kw, n_rnd, n_mix, lat);
        checks++;
        if (obs !== idle_vec()) begin
            errors++;
            $display("[TB] FAIL idle_after_hold obs=%h exp=%h", obs, idle_vec());
        end
        start_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_new_key();
        int n_kw, n_rnd, n_mix, lat;
        run_block(1'b1, 1, 1'b0, n_kw, n_rnd, n_mix, lat);
        checks++;
        if (n_kw !== NR || lat !== 2 * NR + 2) begin
            errors++;
            $display("[TB] FAIL new_key_reexpand kw=%0d lat=%0d exp=%0d/%0d",
                     n_kw, lat, NR, 2 * NR + 2);
        end
    endtask

    task automatic test_back_to_back();
        int n_kw, n_rnd, n_mix, lat;
        for (int b = 0; b < 3; b++) begin
            run_block(1'b0, 0, 1'b1, n_kw, n_rnd, n_mix, lat);
            checks++;
            if (lat !== NR + 2) begin
                errors++;
                $display("[TB] FAIL b2b_latency blk=%0d got=%0d exp=%0d", b, lat, NR + 2);
            end
        end
    endtask

    task automatic test_reset_mid_round();
        int n_kw, n_rnd, n_mix, lat;
        bit expand;
        checks++;
        if (obs !== idle_vec()) begin
            errors++;
            $display("[TB] FAIL mid_round_entry obs=%h exp=%h", obs, idle_vec());
        end
        start_valid = 1'b1;
        new_key = 1'b0;
        expand = !model_key_ok;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start_valid = 1'b0;
            checks++;
            if (obs !== model_out(expand, k)) begin
                errors++;
                $display("[TB] FAIL pre_abort k=%0d obs=%h exp=%h", k, obs, model_out(expand, k));
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== idle_vec()) begin
            errors++;
            $display("[TB] FAIL async_abort obs=%h exp=%h", obs, idle_vec());
        end
        @(posedge clk);
        #1;
        checks++;
        if (obs !== idle_vec()) begin
            errors++;
            $display("[TB] FAIL abort_no_pulse obs=%h exp=%h", obs, idle_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        model_key_ok = 1'b0;
        run_block(1'b0, 0, 1'b0, n_kw, n_rnd, n_mix, lat);
        checks++;
        if (n_kw !== NR) begin
            errors++;
            $display("[TB] FAIL reexpand_after_abort kw=%0d exp=%0d", n_kw, NR);
        end
        // Abort in the middle of key expansion as well
        start_valid = 1'b1;
        new_key = 1'b1;
        repeat (4) begin
            @(negedge clk);
            start_valid = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== idle_vec()) begin
            errors++;
            $display("[TB] FAIL async_abort_keyexp obs=%h exp=%h", obs, idle_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        model_key_ok = 1'b0;
        run_block(1'b0, 0, 1'b0, n_kw, n_rnd, n_mix, lat);
        checks++;
        if (n_kw !== NR) begin
            errors++;
            $display("[TB] FAIL reexpand_after_keyexp_abort kw=%0d exp=%0d", n_kw, NR);
        end
    endtask

    task automatic test_random_blocks();
        int n_kw, n_rnd, n_mix, lat;
        bit nk;
        bit expand;
        for (int b = 0; b < 8; b++) begin
            nk = 1'($urandom);
            expand = nk || !model_key_ok;
            run_block(nk, $urandom_range(0, 3), 1'b0, n_kw, n_rnd, n_mix, lat);
            checks++;
            if (lat !== (expand ? 2 * NR + 2 : NR + 2)) begin
                errors++;
                $display("[TB] FAIL random_latency blk=%0d got=%0d exp=%0d",
                         b, lat, expand ? 2 * NR + 2 : NR + 2);
            end
            start_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                checks++;
                if (obs !== idle_vec()) begin
                    errors++;
                    $display("[TB] FAIL random_gap obs=%h exp=%h", obs, idle_vec());
                end
            end
        end
    endtask

    task automatic test_nr14();
        int n_kw, n_rnd, n_mix, n_ld, max_addr, lat;
        n_kw = 0; n_rnd = 0; n_mix = 0; n_ld = 0; max_addr = 0; lat = -1;
        rst = 1'b1;
        start_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_key_ok = 1'b0;
        checks++;
        if (start_ready_14 !== 1'b1 || out_valid_14 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nr14_idle sr=%b ov=%b exp=1/0", start_ready_14, out_valid_14);
        end
        start_valid = 1'b1;
        new_key = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start_valid = 1'b0;
            if (lat < 0) begin
                n_kw  += int'(key_we_14);
                n_rnd += int'(rnd_en_14);
                n_mix += int'(mix_bypass_14);
                n_ld  += int'(ld_state_14);
                if (int'(key_addr_14) > max_addr) max_addr = int'(key_addr_14);
                if (out_valid_14) lat = k;
            end
        end
        checks++;
        if (n_kw !== NR14 || n_rnd !== NR14 || n_mix !== 1 || n_ld !== 1) begin
            errors++;
            $display("[TB] FAIL nr14_counts kw=%0d rnd=%0d mix=%0d ld=%0d exp=14/14/1/1",
                     n_kw, n_rnd, n_mix, n_ld);
        end
        checks++;
        if (max_addr !== NR14 || lat !== 2 * NR14 + 2) begin
            errors++;
            $display("[TB] FAIL nr14_addr_latency addr=%0d lat=%0d exp=%0d/%0d",
                     max_addr, lat, NR14, 2 * NR14 + 2);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (start_ready_14 !== 1'b1 || out_valid_14 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nr14_release sr=%b ov=%b exp=1/0", start_ready_14, out_valid_14);
        end
    endtask

    // Scenario sequence
    initial begin
        rst = 1'b1;
        start_valid = 1'b0;
        new_key = 1'b0;
        out_ready = 1'b0;
        $display("[TB] cipher_round_ctrl bench start");
        test_reset();
        test_first_block();
        test_cached_key();
        test_done_hold();
        test_new_key();
        test_back_to_back();
        test_reset_mid_round();
        test_random_blocks();
        test_nr14();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
